// File: rtl/alignment_floating_point32.sv
`default_nettype none
// ============================================================================
// Module   : alignment_floating_point32
// Purpose  : Front end of the FP32 adder/subtractor. This block unpacks two
//            single-precision operands and orders them by magnitude. It then
//            aligns the smaller significand to the larger exponent and adds or
//            subtracts the two. The result is the unnormalized
//            {sign, larger_exponent, mantise_temp} triple that feeds the
//            normalizer. Fully pipelined: 3-cycle latency, 1 op per clock.
// Ports    : clk             - clock, rising edge
//            rstn            - asynchronous active-low reset
//            valid_in        - operands valid this cycle
//            sub             - 1: A-B, 0: A+B
//            in_data_a/b     - FP32 operands
//            valid_out       - single-cycle result-valid pulse
//            sign            - result sign
//            larger_exponent - biased exponent of larger-magnitude operand
//            mantise_temp    - raw sum/difference (bit 24 carry, bit 23 hidden)
// Revision : 1.0 - initial release
// ============================================================================
module alignment_floating_point32 (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_in,
  input  logic        sub,
  input  logic [31:0] in_data_a,
  input  logic [31:0] in_data_b,
  output logic        valid_out,
  output logic        sign,
  output logic [7:0]  larger_exponent,
  output logic [24:0] mantise_temp
);

  // --------------------------------------------------------------------------
  // Unpack. A zero exponent flushes the operand (zero or denormal) to a zero
  // significand. B's sign is inverted for subtraction.
  // --------------------------------------------------------------------------
  logic [7:0]  exp_a, exp_b;
  logic [23:0] sig_a, sig_b;
  logic        sign_a, sign_b;
  logic        a_larger;

  assign exp_a  = in_data_a[30:23];
  assign exp_b  = in_data_b[30:23];
  assign sig_a  = (exp_a == 8'd0) ? 24'd0 : {1'b1, in_data_a[22:0]};
  assign sig_b  = (exp_b == 8'd0) ? 24'd0 : {1'b1, in_data_b[22:0]};
  assign sign_a = in_data_a[31];
  assign sign_b = in_data_b[31] ^ sub;

  // The magnitude ordering uses the {exponent, significand} concatenation.
  // A tie selects A. An infinite or NaN operand (exponent FF) always wins
  // this compare, so the FF exponent reaches the output with no special path.
  assign a_larger = ({exp_a, sig_a} >= {exp_b, sig_b});

  // --------------------------------------------------------------------------
  // Stage 1: compare / swap
  // --------------------------------------------------------------------------
  logic        s1_valid;
  logic        s1_sign_l;
  logic [7:0]  s1_exp_l;
  logic [23:0] s1_sig_l;
  logic [23:0] s1_sig_s;
  logic        s1_op;
  logic [7:0]  s1_diff;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_sign_l <= 1'b0;
      s1_exp_l  <= 8'd0;
      s1_sig_l  <= 24'd0;
      s1_sig_s  <= 24'd0;
      s1_op     <= 1'b0;
      s1_diff   <= 8'd0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_op <= sign_a ^ sign_b;
        if (a_larger) begin
          s1_sign_l <= sign_a;
          s1_exp_l  <= exp_a;
          s1_sig_l  <= sig_a;
          s1_sig_s  <= sig_b;
          s1_diff   <= exp_a - exp_b;
        end else begin
          s1_sign_l <= sign_b;
          s1_exp_l  <= exp_b;
          s1_sig_l  <= sig_b;
          s1_sig_s  <= sig_a;
          s1_diff   <= exp_b - exp_a;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: align. Bits shifted out are dropped, with no guard or sticky bits.
  // --------------------------------------------------------------------------
  logic [23:0] aligned_s;
  assign aligned_s = (s1_diff >= 8'd25) ? 24'd0 : (s1_sig_s >> s1_diff);

  logic        s2_valid;
  logic        s2_sign_l;
  logic [7:0]  s2_exp_l;
  logic [23:0] s2_sig_l;
  logic [23:0] s2_sig_s;
  logic        s2_op;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid  <= 1'b0;
      s2_sign_l <= 1'b0;
      s2_exp_l  <= 8'd0;
      s2_sig_l  <= 24'd0;
      s2_sig_s  <= 24'd0;
      s2_op     <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign_l <= s1_sign_l;
        s2_exp_l  <= s1_exp_l;
        s2_sig_l  <= s1_sig_l;
        s2_sig_s  <= aligned_s;
        s2_op     <= s1_op;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: add / subtract. L >= S by construction, so the difference never
  // wraps. An exact-zero result is reported as +0.
  // --------------------------------------------------------------------------
  logic [24:0] result;
  assign result = s2_op ? ({1'b0, s2_sig_l} - {1'b0, s2_sig_s})
                        : ({1'b0, s2_sig_l} + {1'b0, s2_sig_s});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out       <= 1'b0;
      sign            <= 1'b0;
      larger_exponent <= 8'd0;
      mantise_temp    <= 25'd0;
    end else begin
      valid_out <= s2_valid;
      if (s2_valid) begin
        sign            <= (result == 25'd0) ? 1'b0 : s2_sign_l;
        larger_exponent <= s2_exp_l;
        mantise_temp    <= result;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alignment_floating_point32.sv
`default_nettype none
// ============================================================================
// Module   : tb_alignment_floating_point32
// Purpose  : Self-checking bench for alignment_floating_point32. It applies
//            directed vectors with hand-computed results and a streaming
//            burst checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alignment_floating_point32;

  logic        clk;
  logic        rstn;
  logic        valid_in;
  logic        sub;
  logic [31:0] in_data_a;
  logic [31:0] in_data_b;
  logic        valid_out;
  logic        sign;
  logic [7:0]  larger_exponent;
  logic [24:0] mantise_temp;

  int n_tests = 0;
  int n_fail  = 0;

  alignment_floating_point32 dut (
    .clk             (clk),
    .rstn            (rstn),
    .valid_in        (valid_in),
    .sub             (sub),
    .in_data_a       (in_data_a),
    .in_data_b       (in_data_b),
    .valid_out       (valid_out),
    .sign            (sign),
    .larger_exponent (larger_exponent),
    .mantise_temp    (mantise_temp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: returns {sign, exponent, mantissa}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    int unsigned ea, eb, ma, mb, el, es, ml, ms, d, r;
    logic sa, sb, sl, ss, rs;
    ea = a[30:23];
    eb = b[30:23];
    ma = (ea == 0) ? 0 : (32'h800000 | a[22:0]);
    mb = (eb == 0) ? 0 : (32'h800000 | b[22:0]);
    sa = a[31];
    sb = b[31] ^ s;
    if (ea > eb || (ea == eb && ma >= mb)) begin
      el = ea; es = eb; ml = ma; ms = mb; sl = sa; ss = sb;
    end else begin
      el = eb; es = ea; ml = mb; ms = ma; sl = sb; ss = sa;
    end
    d  = el - es;
    ms = (d > 24) ? 0 : (ms >> d);
    r  = (sl != ss) ? (ml - ms) : (ml + ms);
    rs = (r == 0) ? 1'b0 : sl;
    return {rs, el[7:0], r[24:0]};
  endfunction

  // Drives one operation and returns the outputs on the cycle its result
  // is due (3 clocks after it is sampled), plus the valid seen the cycle before.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic early_v, output logic v, output logic [33:0] res);
    @(negedge clk);
    valid_in = 1'b1; sub = s; in_data_a = a; in_data_b = b;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    early_v = valid_out;
    @(negedge clk);
    v   = valid_out;
    res = {sign, larger_exponent, mantise_temp};
  endtask

  task automatic test_reset();
    n_tests++;
    if ({valid_out, sign, larger_exponent, mantise_temp} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0",
               {valid_out, sign, larger_exponent, mantise_temp});
    end
  endtask

  // Directed vector with its own inline comparisons of latency and data.
  task automatic test_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [33:0] exp_res);
    logic ev, v;
    logic [33:0] res;
    run_op(a, b, s, ev, v, res);
    n_tests++;
    if (ev !== 1'b0 || v !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_latency: valid(N+2,N+3)=%b%b expected 01", name, ev, v);
    end
    n_tests++;
    if (res !== exp_res) begin
      n_fail++;
      $display("FAIL %s: got sign=%b exp=%0d mant=%h expected sign=%b exp=%0d mant=%h",
               name, res[33], res[32:25], res[24:0], exp_res[33], exp_res[32:25],
               exp_res[24:0]);
    end
  endtask

  task automatic test_infinity();
    logic ev, v;
    logic [33:0] res;
    run_op(32'h7F800000, 32'h3F800000, 1'b0, ev, v, res);
    n_tests++;
    if (v !== 1'b1 || res[32:25] !== 8'hFF) begin
      n_fail++;
      $display("FAIL infinity: got valid=%b exp=%h expected valid=1 exp=ff", v, res[32:25]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av[8];
    logic [31:0] bv[8];
    logic        sv[8];
    logic [33:0] last;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] ea, eb;
      ea = 8'($urandom_range(1, 254));
      eb = (i % 2 == 0) ? 8'($urandom_range(1, 254)) : ea - 8'($urandom_range(0, 3));
      if (eb == 8'd0) eb = 8'd1;
      av[i] = {1'($urandom), ea, 23'($urandom)};
      bv[i] = {1'($urandom), eb, 23'($urandom)};
      sv[i] = 1'($urandom);
    end
    // The 7th pair is an exact cancellation, which exercises the +0 sign rule.
    bv[6] = av[6] ^ 32'h80000000;
    sv[6] = 1'b0;
    last = model(av[7], bv[7], sv[7]);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        logic [33:0] e;
        e = model(av[c-3], bv[c-3], sv[c-3]);
        n_tests++;
        if (valid_out !== 1'b1 || {sign, larger_exponent, mantise_temp} !== e) begin
          n_fail++;
          $display("FAIL stream_%0d: got valid=%b res=%h expected valid=1 res=%h",
                   c - 3, valid_out, {sign, larger_exponent, mantise_temp}, e);
        end
      end
      if (c < 8) begin
        valid_in = 1'b1; in_data_a = av[c]; in_data_b = bv[c]; sub = sv[c];
      end else begin
        valid_in = 1'b0;
        in_data_a = 32'h12345678; in_data_b = 32'h9ABCDEF0; sub = 1'b1;
      end
    end
    // The output data holds its last value once valid has dropped.
    @(negedge clk);
    n_tests++;
    if (valid_out !== 1'b0 || {sign, larger_exponent, mantise_temp} !== last) begin
      n_fail++;
      $display("FAIL hold: got valid=%b res=%h expected valid=0 res=%h",
               valid_out, {sign, larger_exponent, mantise_temp}, last);
    end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    @(negedge clk);
    valid_in = 1'b1; sub = 1'b0; in_data_a = 32'h3F800000; in_data_b = 32'h3F800000;
    @(negedge clk);
    in_data_a = 32'h40000000; in_data_b = 32'h3F800000;
    @(negedge clk);
    valid_in = 1'b0;
    rstn = 1'b0;
    #1;
    n_tests++;
    if ({valid_out, sign, larger_exponent, mantise_temp} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_midflight_clear: got %h expected 0",
               {valid_out, sign, larger_exponent, mantise_temp});
    end
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid_out !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midflight_novalid: got valid pulse=%b expected 0", seen);
    end
  endtask

  initial begin
    rstn = 1'b0; valid_in = 1'b0; sub = 1'b0; in_data_a = 32'd0; in_data_b = 32'd0;
    repeat (2) @(negedge clk);
    test_reset();
    rstn = 1'b1;

    test_vec("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, {1'b0, 8'd127, 25'h1000000});
    test_vec("one_minus_half", 32'h3F800000, 32'h3F000000, 1'b1, {1'b0, 8'd127, 25'h0400000});
    test_vec("half_minus_one", 32'h3F000000, 32'h3F800000, 1'b1, {1'b1, 8'd127, 25'h0400000});
    test_vec("cancel",        32'h3FC00000, 32'h3FC00000, 1'b1, {1'b0, 8'd127, 25'h0});
    test_vec("diff24",        32'h4B800000, 32'h3F800000, 1'b0, {1'b0, 8'd151, 25'h0800000});
    test_vec("diff30",        32'h4E800000, 32'h3F800000, 1'b0, {1'b0, 8'd157, 25'h0800000});
    test_vec("denormal",      32'h3F800000, 32'h00000001, 1'b0, {1'b0, 8'd127, 25'h0800000});
    test_infinity();
    test_back_to_back();
    test_reset_midflight();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
